// File: rtl/alu_acc_seq.sv
// rtl/alu_acc_seq.sv - parametrised accumulator ALU with command handshake and shift-add multiplier
module alu_acc_seq #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             on,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] operand,
  input  logic             clear_err,
  output logic [WIDTH-1:0] acc,
  output logic             res_valid,
  output logic             overflow,
  output logic [1:0]       state
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    OFF   = 2'b00,
    READY = 2'b01,
    RUN   = 2'b10,
    ERROR = 2'b11
  } stateT;

  stateT              curState, nextState;
  logic [WIDTH-1:0]   accQ, accNext;
  logic               resValidQ, resValidNext;
  logic               overflowQ, overflowNext;
  logic [2*WIDTH-1:0] mcand, product, productNext;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      bitCnt;
  logic               mulStart, mulStep, mulOvf;
  logic [WIDTH:0]     addSum, subDiff;

  assign addSum      = {1'b0, accQ} + {1'b0, operand};
  assign subDiff     = {1'b0, accQ} - {1'b0, operand};
  assign productNext = product + (mplier[0] ? mcand : '0);
  assign mulOvf      = |productNext[2*WIDTH-1:WIDTH];

  always_comb begin
    nextState    = curState;
    accNext      = accQ;
    resValidNext = 1'b0;
    overflowNext = overflowQ;
    mulStart     = 1'b0;
    mulStep      = 1'b0;
    // Dropping enable wins over everything, including a multiply in flight.
    if (!on) begin
      nextState = OFF;
      if (curState == ERROR) overflowNext = 1'b0;
    end else begin
      case (curState)
        OFF: nextState = READY;
        READY: begin
          if (op_valid) begin
            case (opcode)
              3'b000, 3'b001, 3'b010, 3'b011, 3'b111: begin
                resValidNext = 1'b1;
                overflowNext = 1'b0;
                case (opcode)
                  3'b000:  accNext = accQ & operand;
                  3'b001:  accNext = accQ | operand;
                  3'b010:  accNext = accQ ^ operand;
                  3'b011:  accNext = ~accQ;
                  default: accNext = operand;
                endcase
              end
              3'b100: begin
                resValidNext = 1'b1;
                overflowNext = addSum[WIDTH];
                accNext      = addSum[WIDTH-1:0];
                if (addSum[WIDTH]) begin
                  if (SATURATE) accNext = '1;
                  else          nextState = ERROR;
                end
              end
              3'b101: begin
                resValidNext = 1'b1;
                overflowNext = subDiff[WIDTH];
                accNext      = subDiff[WIDTH-1:0];
                if (subDiff[WIDTH]) begin
                  if (SATURATE) accNext = '0;
                  else          nextState = ERROR;
                end
              end
              default: begin
                mulStart  = 1'b1;
                nextState = RUN;
              end
            endcase
          end
        end
        RUN: begin
          mulStep = 1'b1;
          if (bitCnt == CW'(WIDTH - 1)) begin
            resValidNext = 1'b1;
            overflowNext = mulOvf;
            accNext      = (mulOvf && SATURATE) ? '1 : productNext[WIDTH-1:0];
            nextState    = (mulOvf && !SATURATE) ? ERROR : READY;
          end
        end
        default: begin
          if (clear_err) begin
            nextState    = READY;
            overflowNext = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      curState  <= OFF;
      accQ      <= '0;
      resValidQ <= 1'b0;
      overflowQ <= 1'b0;
    end else begin
      curState  <= nextState;
      accQ      <= accNext;
      resValidQ <= resValidNext;
      overflowQ <= overflowNext;
    end
  end

  // Multiplicand shifts left while the multiplier shifts right, one bit per edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      bitCnt  <= '0;
    end else if (mulStart) begin
      mcand   <= {{WIDTH{1'b0}}, accQ};
      mplier  <= operand;
      product <= '0;
      bitCnt  <= '0;
    end else if (mulStep) begin
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      product <= productNext;
      bitCnt  <= bitCnt + CW'(1);
    end
  end

  assign acc       = accQ;
  assign res_valid = resValidQ;
  assign overflow  = overflowQ;
  assign state     = curState;
  assign op_ready  = (curState == READY);

endmodule

// File: tb/tb_alu_acc_seq.sv
// tb/tb_alu_acc_seq.sv - drives a wrapping and a saturating instance with shared directed stimulus
module tb_alu_acc_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       on = 1'b0;
  logic       opValid = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic [7:0] operand = 8'h00;
  logic       clearErr = 1'b0;

  logic [7:0] dAcc[2];
  logic       dReady[2];
  logic       dRv[2];
  logic       dOvf[2];
  logic [1:0] dState[2];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_acc_seq #(.WIDTH(8), .SATURATE(1'b0)) dutWrap (
    .clk(clk), .rst(rst), .on(on), .op_valid(opValid), .op_ready(dReady[0]),
    .opcode(opcode), .operand(operand), .clear_err(clearErr), .acc(dAcc[0]),
    .res_valid(dRv[0]), .overflow(dOvf[0]), .state(dState[0])
  );

  alu_acc_seq #(.WIDTH(8), .SATURATE(1'b1)) dutSat (
    .clk(clk), .rst(rst), .on(on), .op_valid(opValid), .op_ready(dReady[1]),
    .opcode(opcode), .operand(operand), .clear_err(clearErr), .acc(dAcc[1]),
    .res_valid(dRv[1]), .overflow(dOvf[1]), .state(dState[1])
  );

  // Reference model: state names, pending multiply as operands plus a countdown.
  int mAcc[2], mState[2], mLeft[2], mA[2], mB[2];
  bit mRv[2], mOvf[2];

  always @(posedge clk or negedge rst) begin
    for (int s = 0; s < 2; s++) begin
      if (!rst) begin
        mAcc[s] = 0; mState[s] = 0; mRv[s] = 0; mOvf[s] = 0; mLeft[s] = 0;
      end else if (!on) begin
        if (mState[s] == 3) mOvf[s] = 0;
        mState[s] = 0; mRv[s] = 0;
      end else begin
        mRv[s] = 0;
        case (mState[s])
          0: mState[s] = 1;
          1: if (opValid) begin
            int r;
            case (opcode)
              3'd0: begin mAcc[s] = mAcc[s] & operand; mRv[s] = 1; mOvf[s] = 0; end
              3'd1: begin mAcc[s] = mAcc[s] | operand; mRv[s] = 1; mOvf[s] = 0; end
              3'd2: begin mAcc[s] = mAcc[s] ^ operand; mRv[s] = 1; mOvf[s] = 0; end
              3'd3: begin mAcc[s] = 255 - mAcc[s]; mRv[s] = 1; mOvf[s] = 0; end
              3'd7: begin mAcc[s] = operand; mRv[s] = 1; mOvf[s] = 0; end
              3'd4, 3'd5: begin
                r = (opcode == 3'd4) ? mAcc[s] + operand : mAcc[s] - operand;
                mRv[s] = 1;
                mOvf[s] = (r > 255) || (r < 0);
                if (mOvf[s] && s == 1) mAcc[s] = (r > 255) ? 255 : 0;
                else mAcc[s] = (r + 256) % 256;
                if (mOvf[s] && s == 0) mState[s] = 3;
              end
              default: begin
                mA[s] = mAcc[s]; mB[s] = operand; mLeft[s] = 8; mState[s] = 2;
              end
            endcase
          end
          2: begin
            mLeft[s] = mLeft[s] - 1;
            if (mLeft[s] == 0) begin
              int p;
              p = mA[s] * mB[s];
              mRv[s] = 1;
              mOvf[s] = p > 255;
              mAcc[s] = (mOvf[s] && s == 1) ? 255 : p % 256;
              mState[s] = (mOvf[s] && s == 0) ? 3 : 1;
            end
          end
          default: if (clearErr) begin mState[s] = 1; mOvf[s] = 0; end
        endcase
      end
    end
  end

  task automatic check(input string name, input int s, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s dut%0d t=%0t got %0h expected %0h", name, s, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      check("acc", s, dAcc[s], mAcc[s]);
      check("state", s, dState[s], mState[s]);
      check("res_valid", s, dRv[s], mRv[s]);
      check("overflow", s, dOvf[s], mOvf[s]);
      check("op_ready", s, dReady[s], mState[s] == 1);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [2:0] op, input logic [7:0] val);
    opValid = 1'b1; opcode = op; operand = val;
    step(1);
    opValid = 1'b0;
  endtask

  task automatic lit(input string name, input int s, input int acc, input int st, input int ovf);
    check({name, ".acc"}, s, dAcc[s], acc);
    check({name, ".state"}, s, dState[s], st);
    check({name, ".ovf"}, s, dOvf[s], ovf);
  endtask

  initial begin
    step(2);
    lit("reset", 0, 8'h00, 0, 0);
    check("reset.ready", 0, dReady[0], 0);
    rst = 1'b1; on = 1'b1;
    step(1);
    check("powerup.state", 1, dState[1], 1);
    check("powerup.ready", 1, dReady[1], 1);

    cmd(3'd7, 8'h0F);
    check("load.rv", 0, dRv[0], 1);
    cmd(3'd4, 8'h01);
    lit("add", 0, 8'h10, 1, 0);
    check("add.rv", 0, dRv[0], 1);
    cmd(3'd2, 8'hFF);
    lit("xor", 1, 8'hEF, 1, 0);
    cmd(3'd3, 8'h00);
    lit("not", 0, 8'h10, 1, 0);
    step(1);

    cmd(3'd7, 8'hF0);
    cmd(3'd4, 8'h0F);
    lit("addmax", 0, 8'hFF, 1, 0);
    cmd(3'd7, 8'hF0);
    cmd(3'd4, 8'h20);
    lit("addovf", 0, 8'h10, 3, 1);
    check("addovf.ready", 0, dReady[0], 0);
    lit("addsat", 1, 8'hFF, 1, 1);
    cmd(3'd7, 8'h55);
    lit("ignored", 0, 8'h10, 3, 1);
    clearErr = 1'b1;
    cmd(3'd7, 8'h33);
    clearErr = 1'b0;
    lit("clear", 0, 8'h10, 1, 0);

    cmd(3'd7, 8'h09);
    cmd(3'd5, 8'h09);
    lit("subeq", 1, 8'h00, 1, 0);
    cmd(3'd7, 8'h05);
    cmd(3'd5, 8'h09);
    lit("subsat", 1, 8'h00, 1, 1);
    lit("subwrap", 0, 8'hFC, 3, 1);
    clearErr = 1'b1; step(1); clearErr = 1'b0;

    cmd(3'd7, 8'h0C);
    cmd(3'd6, 8'h0A);
    for (int i = 0; i < 8; i++) begin
      check("mulrun.state", 0, dState[0], 2);
      if (i < 7) step(1);
    end
    step(1);
    lit("mul", 0, 8'h78, 1, 0);
    check("mul.rv", 1, dRv[1], 1);
    cmd(3'd7, 8'h20);
    cmd(3'd6, 8'h10);
    step(8);
    lit("mulovf", 0, 8'h00, 3, 1);
    lit("mulsat", 1, 8'hFF, 1, 1);
    clearErr = 1'b1; step(1); clearErr = 1'b0;

    cmd(3'd7, 8'h0C);
    cmd(3'd6, 8'h0A);
    step(2);
    on = 1'b0;
    step(1);
    lit("abort", 0, 8'h0C, 0, 0);
    check("abort.rv", 0, dRv[0], 0);
    step(9);
    on = 1'b1;
    step(1);
    cmd(3'd6, 8'h0A);
    step(3);
    rst = 1'b0;
    #1;
    lit("rstmid", 1, 8'h00, 0, 0);
    step(2);
    rst = 1'b1;
    step(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
